// File: rtl/bram_tdp_param.sv
// True dual-port block RAM with byte write enables, selectable same-port
// read-during-write behaviour, optional output register and a clear sweep.
module bram_tdp_param #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    output logic                    busy,
    input  logic                    ena,
    input  logic                    enb,
    input  logic [DATA_WIDTH/8-1:0] wea,
    input  logic [DATA_WIDTH/8-1:0] web,
    input  logic [ADDR_WIDTH-1:0]   addra,
    input  logic [ADDR_WIDTH-1:0]   addrb,
    input  logic [DATA_WIDTH-1:0]   dia,
    input  logic [DATA_WIDTH-1:0]   dib,
    output logic [DATA_WIDTH-1:0]   doa,
    output logic [DATA_WIDTH-1:0]   dob,
    output logic                    valida,
    output logic                    validb
);

    // state | meaning
    // IDLE  | ports serviced, waiting for clear
    // SWEEP | zeroing word cnt each cycle, ports ignored

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req_a, req_b, in_a, in_b, we_a, we_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, mrg_a, mrg_b, rd_a, rd_b;
    logic [DATA_WIDTH-1:0] d1a, d1b;
    logic                  v1a, v1b;

    assign req_a = ena && !busy;
    assign req_b = enb && !busy;
    assign in_a  = {1'b0, addra} < DEPTH_W;
    assign in_b  = {1'b0, addrb} < DEPTH_W;
    assign we_a  = req_a && in_a;
    assign we_b  = req_b && in_b;

    always_comb begin
        old_a = '0;
        old_b = '0;
        if (in_a) old_a = mem[addra];
        if (in_b) old_b = mem[addrb];
        for (int i = 0; i < NB; i++) begin
            mrg_a[8*i +: 8] = wea[i] ? dia[8*i +: 8] : old_a[8*i +: 8];
            mrg_b[8*i +: 8] = web[i] ? dib[8*i +: 8] : old_b[8*i +: 8];
        end
        // Each port only sees its own merge; the other port's write is never forwarded.
        rd_a = '0;
        rd_b = '0;
        if (in_a) rd_a = (READ_MODE == 1) ? mrg_a : old_a;
        if (in_b) rd_b = (READ_MODE == 1) ? mrg_b : old_b;
    end

    // Port A lanes are assigned last so they win a same-address collision.
    always_ff @(posedge clk) begin
        if (state == SWEEP) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (we_b && web[i]) mem[addrb][8*i +: 8] <= dib[8*i +: 8];
            end
            for (int i = 0; i < NB; i++) begin
                if (we_a && wea[i]) mem[addra][8*i +: 8] <= dia[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= SWEEP;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1a <= '0;
            d1b <= '0;
            v1a <= 1'b0;
            v1b <= 1'b0;
        end else begin
            v1a <= req_a;
            v1b <= req_b;
            if (req_a) d1a <= rd_a;
            if (req_b) d1b <= rd_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            // Second stage keeps running during a sweep so in-flight reads complete.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    doa    <= '0;
                    dob    <= '0;
                    valida <= 1'b0;
                    validb <= 1'b0;
                end else begin
                    valida <= v1a;
                    validb <= v1b;
                    if (v1a) doa <= d1a;
                    if (v1b) dob <= d1b;
                end
            end
        end else begin : g_noreg
            assign doa    = d1a;
            assign dob    = d1b;
            assign valida = v1a;
            assign validb = v1b;
        end
    endgenerate

endmodule

// File: tb/tb_bram_tdp_param.sv
// Directed bench for bram_tdp_param: three instances cover read-first,
// write-first and the DEPTH=48 / OUT_REG=1 geometry.
module tb_bram_tdp_param;

    logic         clk = 1'b0;
    logic         reset, clear, clr2;
    logic         ena, enb;
    logic [15:0]  wea, web;
    logic [5:0]   addra, addrb;
    logic [127:0] dia, dib;

    logic [127:0] doa0, dob0, doa1, dob1, doa2, dob2;
    logic         va0, vb0, va1, vb1, va2, vb2;
    logic         busy0, busy1, busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bram_tdp_param #(.READ_MODE(0)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy0),
        .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
        .dia(dia), .dib(dib), .doa(doa0), .dob(dob0), .valida(va0), .validb(vb0));

    bram_tdp_param #(.READ_MODE(1)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy1),
        .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
        .dia(dia), .dib(dib), .doa(doa1), .dob(dob1), .valida(va1), .validb(vb1));

    bram_tdp_param #(.DEPTH(48), .OUT_REG(1)) u2 (
        .clk(clk), .reset(reset), .clear(clr2), .busy(busy2),
        .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
        .dia(dia), .dib(dib), .doa(doa2), .dob(dob2), .valida(va2), .validb(vb2));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    endtask

    task automatic wra(input logic [5:0] a, input logic [127:0] d, input logic [15:0] m);
        idle();
        ena = 1'b1; addra = a; dia = d; wea = m;
        step();
        idle();
    endtask

    task automatic rda(input logic [5:0] a);
        idle();
        ena = 1'b1; addra = a;
        step();
        idle();
    endtask

    function automatic logic [127:0] pat(input int i);
        return {4{32'hA500_0000 | 32'(i)}};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, vs;
        logic [127:0] x, y, w1, w47, e;
        reset = 1'b1; clear = 1'b0; clr2 = 1'b0;
        idle();
        addra = '0; addrb = '0; dia = '0; dib = '0;
        step(); step();
        chk("rst_doa", doa0, '0);
        chk("rst_dob", dob0, '0);
        chk("rst_va", {127'd0, va0}, 128'd0);
        chk("rst_vb", {127'd0, vb0}, 128'd0);
        chk("rst_busy", {127'd0, busy0}, 128'd0);
        chk("rst_doa2", doa2, '0);
        reset = 1'b0;
        step();

        // write A, read B next cycle
        w1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        wra(6'd5, w1, 16'hFFFF);
        enb = 1'b1; addrb = 6'd5;
        step();
        idle();
        chk("wr_rd_dob", dob0, w1);
        chk("wr_rd_vb", {127'd0, vb0}, 128'd1);
        chk("wr_rd_va_idle", {127'd0, va0}, 128'd0);

        // byte mask
        wra(6'd3, {128{1'b1}}, 16'hFFFF);
        wra(6'd3, '0, 16'h0001);
        rda(6'd3);
        chk("byte_mask", doa0, {{120{1'b1}}, 8'h00});

        // same-port and cross-port read during write
        x = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        y = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
        wra(6'd7, x, 16'hFFFF);
        ena = 1'b1; enb = 1'b1; addra = 6'd7; addrb = 6'd7; dia = y; wea = 16'hFFFF;
        step();
        idle();
        chk("rdw_rf_doa", doa0, x);
        chk("rdw_wf_doa", doa1, y);
        chk("rdw_rf_dob", dob0, x);
        chk("rdw_wf_dob", dob1, x);
        rda(6'd7);
        chk("rdw_after", doa0, y);

        // collision on addr 9
        ena = 1'b1; enb = 1'b1; addra = 6'd9; addrb = 6'd9;
        dia = {16{8'hAA}}; wea = 16'h00FF;
        dib = {16{8'h55}}; web = 16'hFFFF;
        step();
        idle();
        rda(6'd9);
        chk("collision", doa0, {{8{8'h55}}, {8{8'hAA}}});
        rda(6'd9);
        chk("collision_wf", doa1, {{8{8'h55}}, {8{8'hAA}}});

        // full clear sweep
        for (int i = 0; i < 64; i++) wra(6'(i), pat(i), 16'hFFFF);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_busy_rise", {127'd0, busy0}, 128'd1);
        ena = 1'b1; addra = 6'd0;
        bc = 1; vs = 0;
        if (va0) vs++;
        for (int k = 0; k < 100; k++) begin
            step();
            if (!busy0) break;
            bc++;
            if (va0) vs++;
        end
        chk("clr_busy_len", 128'(bc), 128'd64);
        chk("clr_no_valid", 128'(vs), 128'd0);
        chk("clr_fall_valid", {127'd0, va0}, 128'd0);
        step();
        idle();
        chk("clr_accept_valid", {127'd0, va0}, 128'd1);
        chk("clr_accept_data", doa0, '0);
        for (int i = 0; i < 64; i++) begin
            rda(6'(i));
            chk($sformatf("clr_word%0d", i), doa0, '0);
        end

        // reset during sweep cycle 20
        for (int i = 0; i < 64; i++) wra(6'(i), pat(i), 16'hFFFF);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (20) step();
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {127'd0, busy0}, 128'd0);
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 64; i++) begin
            rda(6'(i));
            e = (i < 20) ? 128'd0 : pat(i);
            chk($sformatf("rst_mid_word%0d", i), doa0, e);
        end

        // DEPTH=48, OUT_REG=1 instance
        wra(6'd50, pat(500), 16'hFFFF);
        step(); step();
        ena = 1'b1; addra = 6'd50;
        step();
        idle();
        chk("oor_lat1_valid", {127'd0, va2}, 128'd0);
        step();
        chk("oor_lat2_valid", {127'd0, va2}, 128'd1);
        chk("oor_data", doa2, '0);
        w47 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_5678;
        wra(6'd47, w47, 16'hFFFF);
        step(); step();
        ena = 1'b1; addra = 6'd47;
        step();
        idle();
        chk("lat2_cycle1_valid", {127'd0, va2}, 128'd0);
        step();
        chk("lat2_cycle2_valid", {127'd0, va2}, 128'd1);
        chk("lat2_data", doa2, w47);
        step();
        chk("lat2_valid_pulse", {127'd0, va2}, 128'd0);
        chk("lat2_hold", doa2, w47);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
